// File: rtl/mii_tx_framer.sv
// Ethernet TX framer: stores one frame, pads it, appends the CRC-32 FCS, then sends preamble/SFD/frame/FCS at PHY_WIDTH bits per i_phy_ce beat.
// Latency: the whole frame is buffered before the first PHY beat; s_ready stays low from end of frame until the IFG completes.
`timescale 1ns/1ps
module mii_tx_framer #(
    parameter int PHY_WIDTH   = 4,
    parameter int MTU         = 1518,
    parameter int MIN_FRAME   = 60,
    parameter int IFG_BYTES   = 12,
    parameter int PREAMBLE_EN = 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 s_valid,
    input  logic [7:0]           s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    input  logic                 i_phy_ce,
    output logic                 o_tx_en,
    output logic                 o_tx_er,
    output logic [PHY_WIDTH-1:0] o_txd,
    output logic                 o_busy,
    output logic                 o_drop,
    output logic                 o_frame_done
);
    localparam int CW             = $clog2(MTU + 1);
    localparam int AW             = $clog2(MTU);
    localparam int BEATS_PER_BYTE = 8 / PHY_WIDTH;
    localparam int IFG_BEATS      = IFG_BYTES * BEATS_PER_BYTE;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_DROP,
        S_PAD,
        S_FCS,
        S_PRE,
        S_DATA,
        S_IFG
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        count_q, count_d;
    logic [31:0]          crc_q, crc_d;
    logic [CW-1:0]        idx_q, idx_d;
    logic [2:0]           sub_q, sub_d;
    logic [1:0]           fcs_q, fcs_d;
    logic [15:0]          ifg_q, ifg_d;
    logic [PHY_WIDTH-1:0] txd_q, txd_d;
    logic                 tx_en_q, tx_en_d;
    logic                 drop_q, drop_d;
    logic                 done_q, done_d;

    logic [7:0]           buf_mem [MTU];
    logic                 wr_en;
    logic [AW-1:0]        wr_addr;
    logic [7:0]           wr_dat;

    logic                 xfer;
    logic [CW-1:0]        count_inc;
    logic                 over_mtu;
    logic                 under_min;
    logic [31:0]          fcs_val;
    logic [7:0]           cur_byte;
    logic                 beat_last;
    logic [PHY_WIDTH-1:0] beat_dat;

    function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] dat);
        logic [31:0] c;
        c = crc ^ {24'h0, dat};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign s_ready   = (state_q == S_IDLE) || (state_q == S_FILL) || (state_q == S_DROP);
    assign xfer      = s_valid && s_ready;
    assign count_inc = count_q + CW'(1);
    // Reserve room for the FCS so the buffer can never overflow.
    assign over_mtu  = (32'(count_inc) + 32'd4) > 32'(MTU);
    assign under_min = 32'(count_inc) < 32'(MIN_FRAME);
    assign fcs_val   = ~crc_q;
    assign cur_byte  = (state_q == S_PRE) ? ((idx_q == CW'(7)) ? 8'hD5 : 8'h55)
                                          : buf_mem[idx_q[AW-1:0]];
    assign beat_last = (sub_q == 3'(BEATS_PER_BYTE - 1));
    assign beat_dat  = PHY_WIDTH'(cur_byte >> (32'(sub_q) * PHY_WIDTH));

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        crc_d   = crc_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        fcs_d   = fcs_q;
        ifg_d   = ifg_q;
        txd_d   = txd_q;
        tx_en_d = tx_en_q;
        drop_d  = 1'b0;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_addr = count_q[AW-1:0];
        wr_dat  = 8'h00;

        case (state_q)
            // IDLE always holds count=0 and CRC_INIT, so it shares the FILL path.
            S_IDLE, S_FILL: begin
                if (xfer) begin
                    wr_en   = 1'b1;
                    wr_dat  = s_data;
                    count_d = count_inc;
                    crc_d   = crc_next(crc_q, s_data);
                    if (over_mtu) begin
                        if (s_last) begin
                            drop_d  = 1'b1;
                            state_d = S_IDLE;
                            count_d = '0;
                            crc_d   = CRC_INIT;
                        end else begin
                            state_d = S_DROP;
                        end
                    end else if (s_last) begin
                        state_d = under_min ? S_PAD : S_FCS;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_DROP: begin
                if (xfer && s_last) begin
                    drop_d  = 1'b1;
                    state_d = S_IDLE;
                    count_d = '0;
                    crc_d   = CRC_INIT;
                end
            end
            S_PAD: begin
                wr_en   = 1'b1;
                count_d = count_inc;
                crc_d   = crc_next(crc_q, 8'h00);
                if (32'(count_inc) == 32'(MIN_FRAME)) begin
                    state_d = S_FCS;
                end
            end
            S_FCS: begin
                wr_en   = 1'b1;
                wr_dat  = 8'(fcs_val >> {fcs_q, 3'b000});
                count_d = count_inc;
                fcs_d   = fcs_q + 2'd1;
                if (fcs_q == 2'd3) begin
                    state_d = (PREAMBLE_EN != 0) ? S_PRE : S_DATA;
                    idx_d   = '0;
                    sub_d   = '0;
                end
            end
            S_PRE: begin
                if (i_phy_ce) begin
                    txd_d   = beat_dat;
                    tx_en_d = 1'b1;
                    if (beat_last) begin
                        sub_d = '0;
                        if (idx_q == CW'(7)) begin
                            idx_d   = '0;
                            state_d = S_DATA;
                        end else begin
                            idx_d = idx_q + CW'(1);
                        end
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
            end
            S_DATA: begin
                if (i_phy_ce) begin
                    txd_d   = beat_dat;
                    tx_en_d = 1'b1;
                    if (beat_last) begin
                        sub_d = '0;
                        if (idx_q == count_q - CW'(1)) begin
                            state_d = S_IFG;
                            ifg_d   = '0;
                        end else begin
                            idx_d = idx_q + CW'(1);
                        end
                    end else begin
                        sub_d = sub_q + 3'd1;
                    end
                end
            end
            S_IFG: begin
                if (i_phy_ce) begin
                    txd_d   = '0;
                    tx_en_d = 1'b0;
                    if (ifg_q == 16'(IFG_BEATS - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                        count_d = '0;
                        crc_d   = CRC_INIT;
                    end else begin
                        ifg_d = ifg_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            crc_q   <= CRC_INIT;
            idx_q   <= '0;
            sub_q   <= '0;
            fcs_q   <= '0;
            ifg_q   <= '0;
            txd_q   <= '0;
            tx_en_q <= 1'b0;
            drop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            crc_q   <= crc_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            fcs_q   <= fcs_d;
            ifg_q   <= ifg_d;
            txd_q   <= txd_d;
            tx_en_q <= tx_en_d;
            drop_q  <= drop_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            buf_mem[wr_addr] <= wr_dat;
        end
    end

    assign o_tx_en      = tx_en_q;
    assign o_tx_er      = 1'b0;
    assign o_txd        = txd_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_drop       = drop_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_mii_tx_framer.sv
// Scoreboard bench: dut_a is MII with preamble, padding and a 64-byte MTU; dut_b is RMII, no preamble, no padding.
`timescale 1ns/1ps
module tb_mii_tx_framer;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    logic       a_valid = 1'b0, a_last = 1'b0, a_ce = 1'b0;
    logic [7:0] a_data = 8'h00;
    logic       a_ready, a_tx_en, a_tx_er, a_busy, a_drop, a_done;
    logic [3:0] a_txd;

    logic       b_valid = 1'b0, b_last = 1'b0, b_ce = 1'b0;
    logic [7:0] b_data = 8'h00;
    logic       b_ready, b_tx_en, b_tx_er, b_busy, b_drop, b_done;
    logic [1:0] b_txd;

    mii_tx_framer #(.PHY_WIDTH(4), .MTU(64), .MIN_FRAME(60), .IFG_BYTES(12), .PREAMBLE_EN(1)) dut_a (
        .i_clk(clk), .i_reset(rst), .s_valid(a_valid), .s_data(a_data), .s_last(a_last),
        .s_ready(a_ready), .i_phy_ce(a_ce), .o_tx_en(a_tx_en), .o_tx_er(a_tx_er), .o_txd(a_txd),
        .o_busy(a_busy), .o_drop(a_drop), .o_frame_done(a_done));

    mii_tx_framer #(.PHY_WIDTH(2), .MTU(1518), .MIN_FRAME(0), .IFG_BYTES(12), .PREAMBLE_EN(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .s_valid(b_valid), .s_data(b_data), .s_last(b_last),
        .s_ready(b_ready), .i_phy_ce(b_ce), .o_tx_en(b_tx_en), .o_tx_er(b_tx_er), .o_txd(b_txd),
        .o_busy(b_busy), .o_drop(b_drop), .o_frame_done(b_done));

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_a[$];
    logic [1:0] exp_b[$];
    int len_a[$], len_b[$];
    int done_cnt_a = 0, done_cnt_b = 0, drop_cnt_a = 0;
    int beats_a = 0, beats_b = 0, ifg_a = 0, ifg_b = 0;
    int last_beats_a = 0, last_beats_b = 0;
    bit in_a = 0, in_b = 0;
    int ce_div_a = 1, ce_div_b = 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout expected=DUT event", name);
    endtask

    // Independent bit-serial form of the reflected CRC-32.
    function automatic logic [31:0] fcs_of(input bq_t f);
        logic [31:0] c;
        logic fb;
        c = 32'hFFFF_FFFF;
        foreach (f[i]) begin
            for (int k = 0; k < 8; k++) begin
                fb = c[0] ^ f[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return ~c;
    endfunction

    task automatic build_wire(input bq_t pay, input int min_frame, input bit pre, output bq_t w);
        bq_t body;
        logic [31:0] f;
        body = pay;
        while (body.size() < min_frame) body.push_back(8'h00);
        f = fcs_of(body);
        w.delete();
        if (pre) begin
            repeat (7) w.push_back(8'h55);
            w.push_back(8'hD5);
        end
        foreach (body[i]) w.push_back(body[i]);
        for (int k = 0; k < 4; k++) w.push_back(f[8*k +: 8]);
    endtask

    task automatic push_a(input bq_t w);
        foreach (w[i]) begin
            exp_a.push_back(w[i][3:0]);
            exp_a.push_back(w[i][7:4]);
        end
        len_a.push_back(w.size() * 2);
    endtask

    task automatic push_b(input bq_t w);
        foreach (w[i]) begin
            exp_b.push_back(w[i][1:0]);
            exp_b.push_back(w[i][3:2]);
            exp_b.push_back(w[i][5:4]);
            exp_b.push_back(w[i][7:6]);
        end
        len_b.push_back(w.size() * 4);
    endtask

    task automatic send(input int which, input bq_t f);
        int t;
        for (int i = 0; i < f.size(); i++) begin
            t = 0;
            if (which == 0) begin
                a_valid = 1'b1; a_data = f[i]; a_last = (i == f.size() - 1);
            end else begin
                b_valid = 1'b1; b_data = f[i]; b_last = (i == f.size() - 1);
            end
            while (!((which == 0) ? a_ready : b_ready)) begin
                @(negedge clk);
                t++;
                if (t > 3000) begin
                    fail_timeout("send_ready");
                    a_valid = 1'b0; b_valid = 1'b0;
                    return;
                end
            end
            @(negedge clk);
        end
        a_valid = 1'b0; a_last = 1'b0;
        b_valid = 1'b0; b_last = 1'b0;
    endtask

    task automatic wait_done(input int which, input int target, input int budget);
        int t;
        t = 0;
        while (((which == 0) ? done_cnt_a : done_cnt_b) < target) begin
            @(negedge clk);
            t++;
            if (t > budget) begin
                fail_timeout((which == 0) ? "a_frame_done" : "b_frame_done");
                return;
            end
        end
    endtask

    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            a_ce = (n % ce_div_a) == 0;
        end
    end

    initial begin
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            b_ce = (n % ce_div_b) == 0;
        end
    end

    logic ce_seen_a = 1'b0, ce_seen_b = 1'b0, rst_seen = 1'b1;
    logic [3:0] prev_txd_a = 4'h0;
    logic [1:0] prev_txd_b = 2'h0;
    logic [3:0] pop_a;
    logic [1:0] pop_b;

    always @(posedge clk) begin
        ce_seen_a <= a_ce;
        ce_seen_b <= b_ce;
        rst_seen  <= rst;
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            beats_a = 0; ifg_a = 0; in_a = 0;
        end else begin
            if (ce_seen_a && a_tx_en) begin
                if (exp_a.size() == 0) begin
                    fail_timeout("a_txd_unexpected_beat");
                end else begin
                    pop_a = exp_a.pop_front();
                    chk("a_txd", 32'(a_txd), 32'(pop_a));
                end
                beats_a++;
                in_a = 1;
            end else if (ce_seen_a && in_a) begin
                ifg_a++;
            end
            if (a_txd !== prev_txd_a) chk("a_txd_change_after_ce", 32'(ce_seen_a), 32'd1);
            if (a_done) begin
                chk("a_ifg_beats", ifg_a, 24);
                if (len_a.size() == 0) fail_timeout("a_unexpected_frame_done");
                else chk("a_tx_en_beats", beats_a, len_a.pop_front());
                last_beats_a = beats_a;
                beats_a = 0; ifg_a = 0; in_a = 0;
                done_cnt_a++;
            end
            if (a_drop) drop_cnt_a++;
        end
        prev_txd_a = a_txd;
    end

    always @(negedge clk) begin
        if (rst_seen) begin
            beats_b = 0; ifg_b = 0; in_b = 0;
        end else begin
            if (ce_seen_b && b_tx_en) begin
                if (exp_b.size() == 0) begin
                    fail_timeout("b_txd_unexpected_beat");
                end else begin
                    pop_b = exp_b.pop_front();
                    chk("b_txd", 32'(b_txd), 32'(pop_b));
                end
                beats_b++;
                in_b = 1;
            end else if (ce_seen_b && in_b) begin
                ifg_b++;
            end
            if (b_txd !== prev_txd_b) chk("b_txd_change_after_ce", 32'(ce_seen_b), 32'd1);
            if (b_done) begin
                chk("b_ifg_beats", ifg_b, 48);
                if (len_b.size() == 0) fail_timeout("b_unexpected_frame_done");
                else chk("b_tx_en_beats", beats_b, len_b.pop_front());
                last_beats_b = beats_b;
                beats_b = 0; ifg_b = 0; in_b = 0;
                done_cnt_b++;
            end
            if (b_drop) fail_timeout("b_unexpected_drop");
        end
        prev_txd_b = b_txd;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout expected=bench completion");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bq_t f, w;
        int t, viol;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("a_reset_s_ready", 32'(a_ready), 32'd1);
        chk("a_reset_tx_en", 32'(a_tx_en), 32'd0);
        chk("a_reset_txd", 32'(a_txd), 32'd0);
        chk("a_reset_tx_er", 32'(a_tx_er), 32'd0);
        chk("a_reset_busy", 32'(a_busy), 32'd0);
        chk("a_reset_drop", 32'(a_drop), 32'd0);
        chk("a_reset_frame_done", 32'(a_done), 32'd0);
        chk("b_reset_s_ready", 32'(b_ready), 32'd1);
        chk("b_reset_tx_en", 32'(b_tx_en), 32'd0);
        chk("b_reset_busy", 32'(b_busy), 32'd0);

        // "123456789" with its well-known FCS CBF43926, sent LSB first.
        w = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'h26, 8'h39, 8'hF4, 8'hCB};
        push_b(w);
        f = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        send(1, f);
        wait_done(1, 1, 2000);
        chk("b_check_string_beats", last_beats_b, 52);

        // Single 0xD8 at one beat every fourth cycle: dibits 0,2,1,3 first.
        ce_div_b = 4;
        repeat (8) @(negedge clk);
        f = '{8'hD8};
        build_wire(f, 0, 1'b0, w);
        push_b(w);
        send(1, f);
        wait_done(1, 2, 3000);
        chk("b_slow_ce_beats", last_beats_b, 20);

        // One byte padded to 60 plus preamble and FCS: 72 bytes = 144 nibbles.
        f = '{8'hAB};
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        send(0, f);
        wait_done(0, 1, 1500);
        chk("a_min_frame_beats", last_beats_a, 144);
        repeat (30) @(negedge clk);
        chk("a_frame_done_once", done_cnt_a, 1);

        // Oversize frame is sunk and dropped; the next frame still goes out.
        f.delete();
        for (int i = 0; i < 70; i++) f.push_back(8'(i + 1));
        send(0, f);
        t = 0;
        while (drop_cnt_a < 1 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("a_drop_pulses", drop_cnt_a, 1);
        chk("a_idle_after_drop", 32'(a_busy), 32'd0);
        f.delete();
        for (int i = 0; i < 10; i++) f.push_back(8'(8'hC0 + i));
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        send(0, f);
        wait_done(0, 2, 1500);
        chk("a_after_drop_beats", last_beats_a, 144);

        // Next frame held on the bus during transmission.
        f = '{8'h11};
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        send(0, f);
        f = '{8'h22};
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        a_valid = 1'b1; a_data = 8'h22; a_last = 1'b1;
        t = 0; viol = 0;
        while (a_done !== 1'b1 && t < 1500) begin
            if (a_ready) viol++;
            @(negedge clk);
            t++;
        end
        if (t >= 1500) begin
            fail_timeout("a_held_frame_done");
        end else begin
            chk("a_ready_on_return_to_idle", 32'(a_ready), 32'd1);
            chk("a_ready_low_while_busy", viol, 0);
        end
        @(negedge clk);
        a_valid = 1'b0; a_last = 1'b0;
        chk("a_held_byte_accepted", 32'(a_busy), 32'd1);
        wait_done(0, 4, 1500);

        // Reset in the middle of DATA, then a clean frame.
        f = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        send(0, f);
        t = 0;
        while (beats_a < 20 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) fail_timeout("a_reach_data_state");
        rst = 1'b1;
        @(negedge clk);
        chk("a_midframe_reset_tx_en", 32'(a_tx_en), 32'd0);
        chk("a_midframe_reset_s_ready", 32'(a_ready), 32'd1);
        chk("a_midframe_reset_busy", 32'(a_busy), 32'd0);
        rst = 1'b0;
        exp_a.delete();
        len_a.delete();
        @(negedge clk);
        f = '{8'hA5, 8'h5A, 8'hC3};
        build_wire(f, 60, 1'b1, w);
        push_a(w);
        send(0, f);
        wait_done(0, 5, 1500);

        repeat (5) @(negedge clk);
        chk("a_expected_beats_left", exp_a.size(), 0);
        chk("b_expected_beats_left", exp_b.size(), 0);
        chk("a_total_drops", drop_cnt_a, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
